updown_cnt_monitor: RTL
=======================

Name: updown_cnt_monitor

Overview:
- Receiving end of the up/down counter interface (ctrl in, cnt out).
- Samples the same ctrl the counter sees, plus the counter's cnt bus.
- Predicts the next cnt value and flags illegal steps, counting them.
- Decodes the observed direction and wrap events.
- Tracks lock and re-acquires after loss.
- Sits beside the counter as a synthesizable in-line checker.

Parameters:
- WIDTH, 4: cnt width in bits.
- RST_VAL, 0: counter value required on the first sample after reset release.
- LOSS_THRESH, 3: consecutive mismatches that drop lock (range 1..15).
- RELOCK_CNT, 2: consecutive legal ±1 steps needed to regain lock (range 1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- rst_n  input  1  asynchronous active-low reset.
- ctrl  input  1  direction applied to the counter: 1 = up, 0 = down.
- cnt  input  WIDTH  counter output, registered on the same clk.
- locked  output  1  monitor is tracking and predictions are trusted.
- step_err  output  1  one-cycle pulse: cnt differs from the predicted value.
- err_cnt  output  ERR_W  total errors; saturates at all-ones.
- dir  output  1  decoded direction of the last observed step: 1 = up.
- dir_valid  output  1  last observed step was exactly +1 or -1 (mod 2^WIDTH).
- wrap_up  output  1  pulse: observed step from all-ones to 0.
- wrap_dn  output  1  pulse: observed step from 0 to all-ones.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0.
  - Internal exp, prev, run counters 0.
  - State S_IDLE.
- Counter model: cnt(k+1) = cnt(k) + 1 if ctrl sampled at edge k+1 is 1, else cnt(k) - 1, modulo 2^WIDTH.
- Prediction: at each edge the monitor stores exp = cnt ± 1 using the current ctrl. It compares the cnt present at the following edge against exp.
- Outputs are registered. A bad cnt value visible during cycle n produces step_err high during cycle n+1.
- S_IDLE (first edge after reset release):
  - If cnt != RST_VAL: step_err=1, err_cnt+1, go to S_LOST.
  - Otherwise go to S_TRACK with locked=1.
  - Either way, load exp and prev.
- S_TRACK:
  - On mismatch: step_err=1, err_cnt+1 (saturating), miss_run+1.
  - On match: miss_run=0.
  - If miss_run reaches LOSS_THRESH: go to S_LOST, locked=0 in the same update.
- S_LOST:
  - No step_err and no err_cnt change.
  - Every edge rebaselines exp from the current cnt/ctrl.
  - good_run increments on a legal ±1 step that agrees with the previous ctrl; any other step clears it.
  - When good_run reaches RELOCK_CNT: go to S_TRACK, locked=1, miss_run=0.
- Decoding is active in all states except S_IDLE, with delta = cnt - prev (mod 2^WIDTH):
  - delta = +1: dir=1, dir_valid=1.
  - delta = -1: dir=0, dir_valid=1.
  - Otherwise dir_valid=0 and dir holds.
- Wrap pulses:
  - wrap_up=1 only when prev = all-ones and cnt = 0.
  - wrap_dn=1 only when prev = 0 and cnt = all-ones.
  - Wrap pulses are never both high and are never set on a non-±1 step.
- err_cnt at all-ones stays at all-ones; step_err still pulses.
- Reset mid-operation returns immediately to the reset values; nothing is retained.
- ctrl toggling every cycle is legal and must produce no errors.

Optional Feature:
- Macro: UPDOWN_MON_HOLD_EN.
- Defined:
  - Adds input port en (1 bit), mirroring a counter count-enable.
  - When en=0 the prediction is exp = cnt (hold). A 0 delta is then legal and sets dir_valid=0 with no wrap pulse.
  - A held cycle neither increments nor clears good_run.
- Undefined:
  - No en port.
  - Any 0-delta step is a mismatch in S_TRACK.

Test Plan:
- Release reset with cnt=0, ctrl=1 for 20 cycles -> locked=1 from the first edge, step_err never high, wrap_up pulses once on the 15->0 step, dir=1.
- Reset, then ctrl=0 -> cnt 0->15 step gives wrap_dn=1 for one cycle, dir=0, dir_valid=1, err_cnt=0.
- In S_TRACK force cnt from 5 to 9 for one cycle, then return to a legal sequence -> one step_err pulse, err_cnt=1, locked stays 1.
- Force 3 consecutive wrong values (LOSS_THRESH=3) -> err_cnt=3, locked drops on the 3rd, then 2 legal up steps (7,8,9) -> locked=1 again, err_cnt unchanged during S_LOST.
- Release reset with cnt=4 (RST_VAL=0) -> step_err pulse, err_cnt=1, state S_LOST, locked=0 until RELOCK_CNT legal steps.
- Drive 300 errors with ERR_W=8 -> err_cnt saturates at 255; assert rst_n mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/updown_cnt_monitor.sv
// ============================================================================
// Module   : updown_cnt_monitor
// Purpose  : In-line checker for an up/down counter. It predicts each cnt step,
//            flags and counts bad steps, decodes direction/wrap and tracks lock.
//            Optional count-enable input: define UPDOWN_MON_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_cnt_monitor #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RST_VAL     = '0,
    parameter int               LOSS_THRESH = 3,
    parameter int               RELOCK_CNT  = 2,
    parameter int               ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl,
`ifdef UPDOWN_MON_HOLD_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] cnt,
    output logic             locked,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             dir,
    output logic             dir_valid,
    output logic             wrap_up,
    output logic             wrap_dn
);

    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ONES    = '1;
    localparam logic [WIDTH-1:0] C_ZERO    = '0;
    localparam logic [ERR_W-1:0] C_ERR_ONE = ERR_W'(1);
    localparam logic [3:0]       C_LOSS    = 4'(LOSS_THRESH);
    localparam logic [3:0]       C_RELOCK  = 4'(RELOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_LOST  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_prev;
    logic [3:0]       r_miss_run;
    logic [3:0]       r_good_run;

    logic [WIDTH-1:0] w_exp_next;
    logic [WIDTH-1:0] w_delta;
    logic [ERR_W-1:0] w_err_inc;
    logic             w_mismatch;
    logic             w_step_up;
    logic             w_step_dn;
    logic             w_wrap_up;
    logic             w_wrap_dn;
    logic             w_prev_held;

`ifdef UPDOWN_MON_HOLD_EN
    logic r_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held <= 1'b0;
        end else begin
            r_held <= ~en;
        end
    end

    assign w_prev_held = r_held;
`else
    assign w_prev_held = 1'b0;
`endif

    always_comb begin
        w_exp_next = ctrl ? (cnt + C_ONE) : (cnt - C_ONE);
`ifdef UPDOWN_MON_HOLD_EN
        if (!en) begin
            w_exp_next = cnt;
        end
`endif
    end

    assign w_delta    = cnt - r_prev;
    assign w_mismatch = (cnt != r_exp);
    assign w_step_up  = (w_delta == C_ONE);
    assign w_step_dn  = (w_delta == C_ONES);
    assign w_wrap_up  = (r_prev == C_ONES) && (cnt == C_ZERO);
    assign w_wrap_dn  = (r_prev == C_ZERO) && (cnt == C_ONES);
    // Saturating increment: all-ones stays put.
    assign w_err_inc  = (&err_cnt) ? err_cnt : (err_cnt + C_ERR_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_exp      <= '0;
            r_prev     <= '0;
            r_miss_run <= '0;
            r_good_run <= '0;
            locked     <= 1'b0;
            step_err   <= 1'b0;
            err_cnt    <= '0;
            dir        <= 1'b0;
            dir_valid  <= 1'b0;
            wrap_up    <= 1'b0;
            wrap_dn    <= 1'b0;
        end else begin
            r_exp    <= w_exp_next;
            r_prev   <= cnt;
            step_err <= 1'b0;
            wrap_up  <= 1'b0;
            wrap_dn  <= 1'b0;

            if (r_state != S_IDLE) begin
                dir_valid <= w_step_up | w_step_dn;
                wrap_up   <= w_wrap_up;
                wrap_dn   <= w_wrap_dn;
                if (w_step_up) begin
                    dir <= 1'b1;
                end else if (w_step_dn) begin
                    dir <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_miss_run <= '0;
                    r_good_run <= '0;
                    if (cnt != RST_VAL) begin
                        step_err <= 1'b1;
                        err_cnt  <= w_err_inc;
                        locked   <= 1'b0;
                        r_state  <= S_LOST;
                    end else begin
                        locked  <= 1'b1;
                        r_state <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (w_mismatch) begin
                        step_err <= 1'b1;
                        err_cnt  <= w_err_inc;
                        if ((r_miss_run + 4'd1) == C_LOSS) begin
                            r_miss_run <= '0;
                            r_good_run <= '0;
                            locked     <= 1'b0;
                            r_state    <= S_LOST;
                        end else begin
                            r_miss_run <= r_miss_run + 4'd1;
                        end
                    end else begin
                        r_miss_run <= '0;
                    end
                end
                S_LOST: begin
                    // exp was rebaselined last edge, so a match is a legal step
                    // in the direction of the previous ctrl.
                    if (w_mismatch) begin
                        r_good_run <= '0;
                    end else if (!w_prev_held) begin
                        if ((r_good_run + 4'd1) == C_RELOCK) begin
                            r_good_run <= '0;
                            r_miss_run <= '0;
                            locked     <= 1'b1;
                            r_state    <= S_TRACK;
                        end else begin
                            r_good_run <= r_good_run + 4'd1;
                        end
                    end
                end
                default: begin
                    locked  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
